// File: rtl/fetch_queue_unit.sv
// N-wide instruction fetch stage feeding a circular fetch queue.
// Optional perf counters enabled with `define FQ_PERF_CNT_EN.
//
// Ports:
//   CLK, reset        : clock (rising edge), synchronous active-high reset
//   redirect          : taken branch/jump; flush the queue, restart fetch
//   redirect_pc       : word-aligned restart target
//   stall             : decode stall, nothing dequeued this cycle
//   issue_cnt         : instructions decode consumed this cycle
//   imem_addr         : address of the first word of the fetch group
//   imem_rdata        : WIDTH words from imem_addr, same-cycle read
//   out_valid         : bit i set when entry head+i holds an instruction
//   out_instr         : instruction at head+i, 32 bits per slot
//   out_pc_plus4      : PC+4 of the instruction at head+i
//   fq_count          : current queue occupancy
//   perf_full_cycles  : (FQ_PERF_CNT_EN) cycles fetch was blocked by a full queue
//   perf_flushes      : (FQ_PERF_CNT_EN) cycles with redirect asserted
module fetch_queue_unit #(
    parameter int          WIDTH    = 4,
    parameter int          DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    input  logic                         stall,
    input  logic [$clog2(WIDTH+1)-1:0]   issue_cnt,
    output logic [31:0]                  imem_addr,
    input  logic [32*WIDTH-1:0]          imem_rdata,
    output logic [WIDTH-1:0]             out_valid,
    output logic [32*WIDTH-1:0]          out_instr,
    output logic [32*WIDTH-1:0]          out_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0]   fq_count
`ifdef FQ_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_full_cycles,
    output logic [31:0]                  perf_flushes
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc4   [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc;

    logic [CW:0]   free_slots;
    logic          has_space;
    logic          enq;
    logic [CW-1:0] deq;

    // Space check uses the pre-dequeue count, so a group is only
    // accepted when it fits even if decode consumes nothing.
    assign free_slots = (CW+1)'(DEPTH) - {1'b0, count};
    assign has_space  = free_slots >= (CW+1)'(WIDTH);
    assign enq        = !redirect && has_space;

    // Dequeue is clamped to both the presented width and the
    // number of valid entries, so over-reporting never underflows.
    always_comb begin
        deq = '0;
        if (!stall && !redirect) begin
            deq = CW'(issue_cnt);
            if (deq > CW'(WIDTH)) deq = CW'(WIDTH);
            if (deq > count)      deq = count;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                tail     <= tail + AW'(WIDTH);
                fetch_pc <= fetch_pc + 32'(4*WIDTH);
            end
            head  <= head + AW'(deq);
            count <= count + (enq ? CW'(WIDTH) : '0) - deq;
        end
    end

    // Queue storage needs no reset: validity is tracked by count.
    always_ff @(posedge CLK) begin
        if (!reset && enq) begin
            for (int i = 0; i < WIDTH; i++) begin
                q_instr[tail + AW'(i)] <= imem_rdata[32*i +: 32];
                q_pc4[tail + AW'(i)]   <= fetch_pc + 32'(4*(i+1));
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_out
        logic [AW-1:0] idx;
        assign idx                      = head + AW'(g);
        assign out_valid[g]             = CW'(g) < count;
        assign out_instr[32*g +: 32]    = q_instr[idx];
        assign out_pc_plus4[32*g +: 32] = q_pc4[idx];
    end

    assign imem_addr = fetch_pc;
    assign fq_count  = count;

`ifdef FQ_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            perf_full_cycles <= '0;
            perf_flushes     <= '0;
        end else begin
            if (!redirect && !has_space && perf_full_cycles != 32'hFFFF_FFFF)
                perf_full_cycles <= perf_full_cycles + 32'd1;
            if (redirect && perf_flushes != 32'hFFFF_FFFF)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule
